// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the 2:1 output-path channel mux arbiter.
package mux_arbiter_pkg;

  // One-hot FSM encoding.
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    SERVE_0 = 3'b010,
    SERVE_1 = 3'b100
  } state_t;

  // Burst counter control.
  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_CLEAR = 2'd1,
    CNT_LOAD1 = 2'd2,
    CNT_INC   = 2'd3
  } cnt_op_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int unsigned DEFAULT_MAX_BURST = 4;

  function automatic state_t serve_state(input logic ch);
    return (ch == CH1) ? SERVE_1 : SERVE_0;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// FIFO-side and output-side signals of the channel mux arbiter.
interface mux_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] data_in_0;
  logic [DATA_WIDTH-1:0] data_in_1;
  logic                  fifo_empty_0;
  logic                  fifo_empty_1;
  logic                  out_almost_full;
  logic                  pop_0;
  logic                  pop_1;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  grant_out;

  // The arbiter issues pops and owns the output register.
  modport master (
    input  data_in_0,
    input  data_in_1,
    input  fifo_empty_0,
    input  fifo_empty_1,
    input  out_almost_full,
    output pop_0,
    output pop_1,
    output data_out,
    output valid_out,
    output grant_out
  );

  modport slave (
    output data_in_0,
    output data_in_1,
    output fifo_empty_0,
    output fifo_empty_1,
    output out_almost_full,
    input  pop_0,
    input  pop_1,
    input  data_out,
    input  valid_out,
    input  grant_out
  );

endinterface

// File: rtl/mux_arbiter_burst_counter.sv
// Saturating burst-length counter with clear, load-1, increment and hold.
module mux_arbiter_burst_counter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST,
  parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  cnt_op_t          op,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case (op)
        CNT_CLEAR: cnt <= '0;
        CNT_LOAD1: cnt <= CNT_W'(1);
        CNT_INC:   if (cnt != MAX_CNT) cnt <= cnt + 1'b1;
        default:   cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for two FWFT FIFOs feeding one registered output,
// with bounded bursts and downstream almost-full stall.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic          clk,
  input  logic          reset,
  mux_arbiter_if.master bus
);

  localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] burst_cnt;
  cnt_op_t          cnt_op;

  logic elig_0, elig_1, stall;
  logic cur, elig_cur, elig_oth, burst_sat;
  logic grant, tgt;
  logic pop_0, pop_1;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  grant_q;

  assign elig_0    = ~bus.fifo_empty_0;
  assign elig_1    = ~bus.fifo_empty_1;
  assign stall     = bus.out_almost_full;
  assign cur       = (state_q == SERVE_1) ? CH1 : CH0;
  assign elig_cur  = (cur == CH1) ? elig_1 : elig_0;
  assign elig_oth  = (cur == CH1) ? elig_0 : elig_1;
  assign burst_sat = (burst_cnt == MAX_CNT);

  // Grant decision; reset gating keeps both pops low while reset is held.
  always_comb begin
    grant = 1'b0;
    tgt   = CH0;
    if (!reset && !stall && (elig_0 || elig_1)) begin
      case (state_q)
        IDLE: begin
          grant = 1'b1;
          if (elig_0 && elig_1) tgt = ~last_q;
          else                  tgt = elig_1 ? CH1 : CH0;
        end
        SERVE_0, SERVE_1: begin
          grant = 1'b1;
          if (!elig_cur)                 tgt = ~cur;
          else if (burst_sat && elig_oth) tgt = ~cur;
          else                            tgt = cur;
        end
        default: grant = 1'b0;
      endcase
    end
  end

  assign pop_0 = grant && (tgt == CH0);
  assign pop_1 = grant && (tgt == CH1);

  // Stall freezes everything; running dry returns to IDLE but keeps last.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_op  = CNT_HOLD;
    if (grant) begin
      state_d = serve_state(tgt);
      last_d  = tgt;
      cnt_op  = ((state_q != IDLE) && (tgt == cur)) ? CNT_INC : CNT_LOAD1;
    end else if (!stall) begin
      state_d = IDLE;
      cnt_op  = CNT_CLEAR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= CH1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  mux_arbiter_burst_counter #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_burst_counter (
    .clk   (clk),
    .reset (reset),
    .op    (cnt_op),
    .cnt   (burst_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      valid_q <= pop_0 | pop_1;
      grant_q <= pop_1;
      if (pop_1)      data_q <= bus.data_in_1;
      else if (pop_0) data_q <= bus.data_in_0;
      else            data_q <= '0;
    end
  end

  assign bus.pop_0     = pop_0;
  assign bus.pop_1     = pop_1;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.grant_out = grant_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: FIFO queues model the FWFT sources.
module tb_mux_arbiter;
  import mux_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  mux_arbiter_if #(.DATA_WIDTH(8)) ifc ();

  mux_arbiter #(
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic e0, input logic e1);
    chk({tag, ".pop_0"}, {31'd0, ifc.pop_0}, {31'd0, e0});
    chk({tag, ".pop_1"}, {31'd0, ifc.pop_1}, {31'd0, e1});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic g, input logic [7:0] d);
    chk({tag, ".valid_out"}, {31'd0, ifc.valid_out}, {31'd0, v});
    chk({tag, ".grant_out"}, {31'd0, ifc.grant_out}, {31'd0, g});
    chk({tag, ".data_out"},  {24'd0, ifc.data_out},  {24'd0, d});
  endtask

  task automatic drive();
    ifc.fifo_empty_0 = (q0.size() == 0);
    ifc.fifo_empty_1 = (q1.size() == 0);
    ifc.data_in_0    = (q0.size() != 0) ? q0[0] : 8'h00;
    ifc.data_in_1    = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  // Pops seen just before the edge retire the FIFO heads after it.
  task automatic tick();
    logic p0, p1;
    @(negedge clk);
    p0 = ifc.pop_0;
    p1 = ifc.pop_1;
    @(posedge clk);
    #1;
    if (p0 && q0.size() != 0) q0.delete(0);
    if (p1 && q1.size() != 0) q1.delete(0);
    settle();
  endtask

  task automatic load_q(input int ch, input logic [7:0] base, input int n);
    if (ch == 0) q0.delete(); else q1.delete();
    for (int i = 0; i < n; i++) begin
      if (ch == 0) q0.push_back(base + 8'(i));
      else         q1.push_back(base + 8'(i));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.out_almost_full = 1'b0;
    settle();
    tick();
    tick();
  endtask

  logic       pat[12];
  logic [7:0] e0, e1, prev_d;

  initial begin
    // Reset with both FIFOs non-empty
    reset = 1'b1;
    ifc.out_almost_full = 1'b0;
    load_q(0, 8'h01, 3);
    load_q(1, 8'h81, 2);
    settle();
    chk_pop("rst_comb", 1'b0, 1'b0);
    tick();
    chk_pop("rst_c1", 1'b0, 1'b0);
    chk_out("rst_c1", 1'b0, 1'b0, 8'h00);
    tick();
    chk_pop("rst_c2", 1'b0, 1'b0);
    chk_out("rst_c2", 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    settle();
    chk_pop("rel_first", 1'b1, 1'b0);
    tick();
    chk_out("rel_out", 1'b1, 1'b0, 8'h01);

    // Single channel: only FIFO 1 holds A1..A3
    do_reset();
    load_q(0, 8'h00, 0);
    load_q(1, 8'hA1, 3);
    reset = 1'b0;
    settle();
    chk_pop("single_c0", 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("single_out", 1'b1, 1'b1, 8'hA1 + 8'(k));
      chk_pop("single_pop", 1'b0, (k < 2));
    end
    tick();
    chk_out("single_idle", 1'b0, 1'b0, 8'h00);
    chk_pop("single_idle", 1'b0, 1'b0);

    // Fairness: both FIFOs always full, bursts of 4
    do_reset();
    load_q(0, 8'h00, 16);
    load_q(1, 8'h80, 16);
    reset = 1'b0;
    settle();
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e0 = 8'h00;
    e1 = 8'h80;
    prev_d = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        tick();
        chk_out("fair_out", 1'b1, pat[i-1], prev_d);
      end
      chk_pop("fair_pop", ~pat[i], pat[i]);
      prev_d = pat[i] ? e1 : e0;
      if (pat[i]) e1 = e1 + 8'd1;
      else        e0 = e0 + 8'd1;
    end

    // Backpressure after the 2nd pop of a channel-0 burst
    do_reset();
    load_q(0, 8'h00, 16);
    load_q(1, 8'h80, 16);
    reset = 1'b0;
    settle();
    chk_pop("bp_c0", 1'b1, 1'b0);
    tick();
    chk_pop("bp_c1", 1'b1, 1'b0);
    chk_out("bp_c1", 1'b1, 1'b0, 8'h00);
    tick();
    ifc.out_almost_full = 1'b1;
    settle();
    chk_pop("bp_c2", 1'b0, 1'b0);
    chk_out("bp_c2", 1'b1, 1'b0, 8'h01);
    tick();
    chk_pop("bp_c3", 1'b0, 1'b0);
    chk_out("bp_c3", 1'b0, 1'b0, 8'h00);
    tick();
    chk_pop("bp_c4", 1'b0, 1'b0);
    chk_out("bp_c4", 1'b0, 1'b0, 8'h00);
    tick();
    ifc.out_almost_full = 1'b0;
    settle();
    chk_pop("bp_c5", 1'b1, 1'b0);
    chk_out("bp_c5", 1'b0, 1'b0, 8'h00);
    tick();
    chk_pop("bp_c6", 1'b1, 1'b0);
    chk_out("bp_c6", 1'b1, 1'b0, 8'h02);
    tick();
    chk_pop("bp_c7", 1'b0, 1'b1);
    chk_out("bp_c7", 1'b1, 1'b0, 8'h03);
    tick();
    chk_out("bp_c8", 1'b1, 1'b1, 8'h80);

    // Early empty: FIFO 0 runs dry after 2 pops, burst restarts on channel 1
    do_reset();
    load_q(0, 8'h10, 2);
    load_q(1, 8'h80, 16);
    reset = 1'b0;
    settle();
    chk_pop("ee_c0", 1'b1, 1'b0);
    tick();
    chk_pop("ee_c1", 1'b1, 1'b0);
    chk_out("ee_c1", 1'b1, 1'b0, 8'h10);
    tick();
    chk_pop("ee_c2", 1'b0, 1'b1);
    chk_out("ee_c2", 1'b1, 1'b0, 8'h11);
    tick();
    load_q(0, 8'h20, 16);
    settle();
    chk_pop("ee_c3", 1'b0, 1'b1);
    chk_out("ee_c3", 1'b1, 1'b1, 8'h80);
    tick();
    chk_pop("ee_c4", 1'b0, 1'b1);
    chk_out("ee_c4", 1'b1, 1'b1, 8'h81);
    tick();
    chk_pop("ee_c5", 1'b0, 1'b1);
    chk_out("ee_c5", 1'b1, 1'b1, 8'h82);
    tick();
    chk_pop("ee_c6", 1'b1, 1'b0);
    chk_out("ee_c6", 1'b1, 1'b1, 8'h83);
    tick();
    chk_out("ee_c7", 1'b1, 1'b0, 8'h20);

    // Burst expires as both FIFOs drain; next tie goes to channel 1
    do_reset();
    load_q(0, 8'h30, 4);
    load_q(1, 8'h00, 0);
    reset = 1'b0;
    settle();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk_pop("drain_pop", 1'b1, 1'b0);
    end
    tick();
    chk_pop("drain_c4", 1'b0, 1'b0);
    chk_out("drain_c4", 1'b1, 1'b0, 8'h33);
    tick();
    chk_out("drain_c5", 1'b0, 1'b0, 8'h00);
    load_q(0, 8'h40, 4);
    load_q(1, 8'hC0, 4);
    settle();
    chk_pop("drain_tie", 1'b0, 1'b1);
    tick();
    chk_out("drain_tie_out", 1'b1, 1'b1, 8'hC0);

    // Reset during the 3rd channel-1 pop
    do_reset();
    load_q(0, 8'h00, 0);
    load_q(1, 8'h80, 16);
    reset = 1'b0;
    settle();
    chk_pop("mr_c0", 1'b0, 1'b1);
    tick();
    chk_pop("mr_c1", 1'b0, 1'b1);
    chk_out("mr_c1", 1'b1, 1'b1, 8'h80);
    tick();
    reset = 1'b1;
    load_q(0, 8'h50, 8);
    settle();
    chk_pop("mr_c2", 1'b0, 1'b0);
    chk_out("mr_c2", 1'b1, 1'b1, 8'h81);
    tick();
    chk_out("mr_c3", 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    settle();
    chk_pop("mr_rel", 1'b1, 1'b0);
    tick();
    chk_out("mr_rel_out", 1'b1, 1'b0, 8'h50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
